// File: rtl/ia_sparse_encoder_pkg.sv
// rtl/ia_sparse_encoder_pkg.sv - shared defaults, state encoding and width helpers for the IA sparse encoder
package ia_sparse_encoder_pkg;

  localparam int IA_CHANNEL_DEF       = 32;
  localparam int IA_DATA_BITWIDTH_DEF = 8;
  localparam int IA_C_BITWIDTH_DEF    = 5;
  localparam int IA_ROW_DEF           = 32;
  localparam int IA_COL_DEF           = 32;
  localparam int LANES_DEF            = 4;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_OUT     = 1'b1
  } state_e;

  // A length field must hold 0..n inclusive.
  function automatic int len_bits(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int IA_LEN_BITWIDTH = len_bits(IA_CHANNEL_DEF);

endpackage

// File: rtl/ia_sparse_encoder_lane_compactor.sv
// rtl/ia_sparse_encoder_lane_compactor.sv - per-beat nonzero mask, prefix offsets and popcount
module ia_sparse_encoder_lane_compactor
  import ia_sparse_encoder_pkg::*;
#(
  parameter int LANES            = LANES_DEF,
  parameter int IA_DATA_BITWIDTH = IA_DATA_BITWIDTH_DEF
) (
  input  logic [LANES-1:0][IA_DATA_BITWIDTH-1:0] lanes,
  output logic [LANES-1:0]                       nz_mask,
  output logic [LANES-1:0][$clog2(LANES):0]      offset,
  output logic [$clog2(LANES):0]                 popcount
);

  localparam int OFF_W = $clog2(LANES) + 1;

  always_comb begin
    logic [OFF_W-1:0] run;
    run     = '0;
    nz_mask = '0;
    offset  = '0;
    // offset[j] counts nonzero lanes strictly below j, so packing keeps channel order.
    for (int j = 0; j < LANES; j++) begin
      nz_mask[j] = |lanes[j];
      offset[j]  = run;
      run        = run + OFF_W'(|lanes[j]);
    end
    popcount = run;
  end

endmodule

// File: rtl/ia_sparse_encoder.sv
// rtl/ia_sparse_encoder.sv - compacts dense IA channel beats into one sparse pixel bundle with valid/ready output
module ia_sparse_encoder
  import ia_sparse_encoder_pkg::*;
#(
  parameter int IA_CHANNEL       = IA_CHANNEL_DEF,
  parameter int IA_DATA_BITWIDTH = IA_DATA_BITWIDTH_DEF,
  parameter int IA_C_BITWIDTH    = IA_C_BITWIDTH_DEF,
  parameter int IA_ROW           = IA_ROW_DEF,
  parameter int IA_COL           = IA_COL_DEF,
  parameter int LANES            = LANES_DEF
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_valid,
  output logic                                        o_ready,
  input  logic [LANES-1:0][IA_DATA_BITWIDTH-1:0]      i_data,
  input  logic                                        i_last,
  input  logic [$clog2(IA_ROW):0]                     i_h,
  input  logic [$clog2(IA_COL):0]                     i_w,
  output logic                                        o_valid,
  input  logic                                        i_ready,
  output logic [IA_CHANNEL-1:0][IA_DATA_BITWIDTH-1:0] o_ia_data,
  output logic [IA_CHANNEL-1:0][IA_C_BITWIDTH-1:0]    o_ia_c_idx,
  output logic [$clog2(IA_CHANNEL):0]                 o_ia_len,
  output logic [$clog2(IA_ROW):0]                     o_ia_h,
  output logic [$clog2(IA_COL):0]                     o_ia_w,
  output logic                                        o_err
);

  localparam int LEN_W = len_bits(IA_CHANNEL);
  localparam int IDX_W = $clog2(IA_CHANNEL);
  localparam int OFF_W = $clog2(LANES) + 1;

  state_e                        state;
  logic [LEN_W-1:0]              base;
  logic                          first;
  logic [LANES-1:0]              nz_mask;
  logic [LANES-1:0][OFF_W-1:0]   offset;
  logic [OFF_W-1:0]              popcount;
  logic [LEN_W-1:0]              cur_len;
  logic [LANES-1:0][IDX_W-1:0]   slot_idx;
  logic [LANES-1:0][IA_C_BITWIDTH-1:0] chan_idx;
  logic                          overflow;

  ia_sparse_encoder_lane_compactor #(
    .LANES            (LANES),
    .IA_DATA_BITWIDTH (IA_DATA_BITWIDTH)
  ) u_compactor (
    .lanes    (i_data),
    .nz_mask  (nz_mask),
    .offset   (offset),
    .popcount (popcount)
  );

  assign o_valid  = (state == S_OUT);
  assign o_ready  = (state == S_COLLECT);
  assign overflow = (base >= LEN_W'(IA_CHANNEL));
  // The first beat of a pixel packs from slot 0 regardless of the stale length.
  assign cur_len  = first ? '0 : o_ia_len;

  always_comb begin
    slot_idx = '0;
    chan_idx = '0;
    for (int j = 0; j < LANES; j++) begin
      slot_idx[j] = IDX_W'(cur_len + LEN_W'(offset[j]));
      chan_idx[j] = IA_C_BITWIDTH'(base + LEN_W'(j));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_COLLECT;
      base       <= '0;
      first      <= 1'b1;
      o_ia_len   <= '0;
      o_ia_h     <= '0;
      o_ia_w     <= '0;
      o_err      <= 1'b0;
      o_ia_data  <= '0;
      o_ia_c_idx <= '0;
    end else if (state == S_COLLECT) begin
      if (i_valid) begin
        if (first) begin
          o_ia_data  <= '0;
          o_ia_c_idx <= '0;
          o_ia_h     <= i_h;
          o_ia_w     <= i_w;
        end
        if (overflow) begin
          if (!i_last) o_err <= 1'b1;
        end else begin
          // Later nonblocking writes override the first-beat clear above.
          for (int j = 0; j < LANES; j++) begin
            if (nz_mask[j]) begin
              o_ia_data[slot_idx[j]]  <= i_data[j];
              o_ia_c_idx[slot_idx[j]] <= chan_idx[j];
            end
          end
          o_ia_len <= cur_len + LEN_W'(popcount);
          base     <= base + LEN_W'(LANES);
        end
        first <= 1'b0;
        if (i_last) state <= S_OUT;
      end
    end else begin
      if (i_ready) begin
        state <= S_COLLECT;
        base  <= '0;
        first <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ia_sparse_encoder.sv
// tb/tb_ia_sparse_encoder.sv - scoreboard bench for ia_sparse_encoder with a dense-to-sparse reference model
module tb_ia_sparse_encoder;

  localparam int CH = 32;
  localparam int LN = 4;
  localparam int DW = 8;
  localparam int CW = 5;
  localparam int LW = 6;
  localparam int HW = 6;
  localparam int MAXC = 48;

  logic                    i_clk;
  logic                    i_rst_n;
  logic                    i_valid;
  logic                    o_ready;
  logic [LN-1:0][DW-1:0]   i_data;
  logic                    i_last;
  logic [HW-1:0]           i_h;
  logic [HW-1:0]           i_w;
  logic                    o_valid;
  logic                    i_ready;
  logic [CH-1:0][DW-1:0]   o_ia_data;
  logic [CH-1:0][CW-1:0]   o_ia_c_idx;
  logic [LW-1:0]           o_ia_len;
  logic [HW-1:0]           o_ia_h;
  logic [HW-1:0]           o_ia_w;
  logic                    o_err;

  ia_sparse_encoder dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_last     (i_last),
    .i_h        (i_h),
    .i_w        (i_w),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_ia_data  (o_ia_data),
    .o_ia_c_idx (o_ia_c_idx),
    .o_ia_len   (o_ia_len),
    .o_ia_h     (o_ia_h),
    .o_ia_w     (o_ia_w),
    .o_err      (o_err)
  );

  typedef struct {
    int len;
    int data[CH];
    int cidx[CH];
    int h;
    int w;
    bit err;
  } exp_t;

  exp_t                  sb[$];
  int                    vectors = 0;
  int                    miscompares = 0;
  bit                    exp_err = 0;
  int                    hold_cycles = 0;
  logic signed [DW-1:0]  pix [MAXC];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Random backpressure, with forced-low windows requested by the stimulus.
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (hold_cycles > 0) begin
        i_ready = 1'b0;
        hold_cycles--;
      end else begin
        i_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: every cycle the bundle is presented it must match the oldest expected pixel.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_valid) begin
        check("ready_low_in_out", int'(o_ready), 0);
        if (sb.size() == 0) begin
          check("unexpected_valid", int'(o_valid), 0);
        end else begin
          check("len", int'(o_ia_len), sb[0].len);
          check("h", int'(o_ia_h), sb[0].h);
          check("w", int'(o_ia_w), sb[0].w);
          check("err", int'(o_err), int'(sb[0].err));
          for (int k = 0; k < CH; k++) begin
            check($sformatf("data[%0d]", k), int'($signed(o_ia_data[k])), sb[0].data[k]);
            check($sformatf("c_idx[%0d]", k), int'(o_ia_c_idx[k]), sb[0].cidx[k]);
          end
          if (i_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input int b, input bit last, input int h, input int w);
    int t;
    for (int j = 0; j < LN; j++) i_data[j] = pix[b*LN + j];
    i_last  = last;
    i_h     = HW'(h);
    i_w     = HW'(w);
    i_valid = 1'b1;
    t = 0;
    while (!o_ready && t < 1000) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    if (!o_ready) begin
      check("beat_accept_timeout", int'(o_ready), 1);
      i_valid = 1'b0;
      return;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Reference: channels past the last beat are zero, channels past CH are dropped,
  // nonzeros listed in ascending channel order.
  task automatic send_pixel(input int nbeats, input int h, input int w);
    exp_t e;
    int   v;
    e.len = 0;
    for (int k = 0; k < CH; k++) begin
      e.data[k] = 0;
      e.cidx[k] = 0;
    end
    for (int c = 0; c < CH; c++) begin
      v = (c < nbeats * LN) ? int'(pix[c]) : 0;
      if (v != 0) begin
        e.data[e.len] = v;
        e.cidx[e.len] = c;
        e.len++;
      end
    end
    if (nbeats >= CH/LN + 2) exp_err = 1'b1;
    e.h   = h;
    e.w   = w;
    e.err = exp_err;
    for (int b = 0; b < nbeats; b++) send_beat(b, (b == nbeats - 1), h, w);
    sb.push_back(e);
    check("latency_o_valid", int'(o_valid), 1);
  endtask

  task automatic fill_random(input int nch);
    int density;
    density = $urandom_range(0, 4);
    for (int c = 0; c < MAXC; c++) begin
      if (c < nch && $urandom_range(0, 3) < density) pix[c] = DW'($urandom_range(1, 255));
      else pix[c] = '0;
    end
  endtask

  task automatic clear_pix();
    for (int c = 0; c < MAXC; c++) pix[c] = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || o_valid) && t < 2000) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_valid", int'(o_valid), 0);
    check("rst_ready", int'(o_ready), 1);
    check("rst_len", int'(o_ia_len), 0);
    check("rst_h", int'(o_ia_h), 0);
    check("rst_w", int'(o_ia_w), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_data_zero", int'(|o_ia_data), 0);
    check("rst_cidx_zero", int'(|o_ia_c_idx), 0);
  endtask

  initial begin
    int nb;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = '0;
    i_h     = '0;
    i_w     = '0;
    clear_pix();
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_state();
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Sparse pixel from the directed example.
    clear_pix();
    pix[3] = 8'sd5;
    pix[10] = -8'sd2;
    pix[31] = 8'sd7;
    send_pixel(8, 2, 9);

    // Fully dense pixel.
    for (int c = 0; c < CH; c++) pix[c] = DW'(c + 1);
    send_pixel(8, 5, 17);

    // All-zero pixel followed by a random one.
    clear_pix();
    send_pixel(8, 31, 0);
    fill_random(CH);
    send_pixel(8, 7, 3);

    // Backpressure with the next pixel already waiting on i_valid.
    wait_idle();
    fill_random(LN);
    hold_cycles = 8;
    send_pixel(1, 11, 12);
    fill_random(CH);
    send_pixel(8, 13, 14);

    // Early i_last on the second beat.
    clear_pix();
    pix[1] = 8'sd4;
    pix[6] = -8'sd1;
    send_pixel(2, 1, 1);

    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, CH/LN);
      fill_random(nb * LN);
      send_pixel(nb, $urandom_range(0, 63), $urandom_range(0, 63));
    end

    // Overflow: beats 9 and 10 are discarded and the error sticks.
    fill_random(MAXC);
    send_pixel(10, 20, 21);
    fill_random(LN * 9);
    send_pixel(9, 22, 23);
    for (int p = 0; p < 5; p++) begin
      nb = $urandom_range(1, CH/LN);
      fill_random(nb * LN);
      send_pixel(nb, $urandom_range(0, 63), $urandom_range(0, 63));
    end

    // Reset in the middle of a pixel, then a clean pixel.
    wait_idle();
    for (int c = 0; c < MAXC; c++) pix[c] = DW'($urandom_range(1, 255));
    for (int b = 0; b < 3; b++) send_beat(b, 1'b0, 9, 9);
    i_rst_n = 1'b0;
    exp_err = 1'b0;
    #1;
    check_reset_state();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("post_rst_ready", int'(o_ready), 1);
    fill_random(CH);
    send_pixel(8, 4, 6);

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
